md_ctrl: RTL and testbench

Multiply/divide sequencer for the five-stage pipeline. It accepts mult/multu/div/divu/mthi/mtlo issued from EXE, holds the operands, and counts out a fixed multi-cycle latency. At the end of that latency it commits the result to the architectural HI/LO registers. It also produces the stall request that holds a HI/LO-dependent instruction in ID until the unit is free, and it ORs into the existing hazard stall.

---
 rtl/mips_md_pkg.sv | 40 ++++
 rtl/md_ctrl_if.sv | 25 ++
 rtl/md_core.sv | 51 +++++
 rtl/md_ctrl.sv | 120 ++++++++++++
 tb/tb_md_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/mips_md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings,
// FSM state type, default latencies and op-class helpers.
package mips_md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int unsigned MULT_CYCLES_DEF = 32'd5;
    localparam int unsigned DIV_CYCLES_DEF  = 32'd10;

    function automatic logic is_muldiv(input logic [2:0] op);
        logic r;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        logic r;
        case (op)
            MD_DIV, MD_DIVU: r = 1'b1;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// EXE/ID-side handshake bundle of the multiply/divide sequencer.
interface md_ctrl_if;
    import mips_md_pkg::*;

    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        md_useD;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, src_a, src_b, md_useD,
        input  busy, stall_md, hi, lo
    );

    modport slave (
        input  start, md_op, src_a, src_b, md_useD,
        output busy, stall_md, hi, lo
    );

endinterface

// File: rtl/md_core.sv
// Combinational multiply/divide datapath. Division works on magnitudes and
// re-applies signs, so 0x80000000 / -1 wraps to 0x80000000 without a special case.
module md_core
    import mips_md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_zero
);

    logic [63:0] sprod_s;
    logic [63:0] uprod_s;
    logic        neg_a_s;
    logic        neg_b_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic [31:0] dvs_s;
    logic [31:0] q_u_s;
    logic [31:0] r_u_s;
    logic [31:0] q_s;
    logic [31:0] r_s;

    assign sprod_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign uprod_s  = {32'd0, a} * {32'd0, b};

    assign neg_a_s  = (op == MD_DIV) & a[31];
    assign neg_b_s  = (op == MD_DIV) & b[31];
    assign mag_a_s  = neg_a_s ? (32'd0 - a) : a;
    assign mag_b_s  = neg_b_s ? (32'd0 - b) : b;
    assign div_zero = is_div(op) & (b == 32'd0);
    // Divisor of zero is replaced so the divider never sees it; result is discarded anyway
    assign dvs_s    = div_zero ? 32'd1 : mag_b_s;
    assign q_u_s    = mag_a_s / dvs_s;
    assign r_u_s    = mag_a_s % dvs_s;
    assign q_s      = (neg_a_s ^ neg_b_s) ? (32'd0 - q_u_s) : q_u_s;
    assign r_s      = neg_a_s ? (32'd0 - r_u_s) : r_u_s;

    // Select the {hi,lo} pair for the latched op
    always_comb begin
        result = 64'd0;
        case (op)
            MD_MULT:         result = sprod_s;
            MD_MULTU:        result = uprod_s;
            MD_DIV, MD_DIVU: result = {r_s, q_s};
            default:         result = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: latches operands, counts out the op latency,
// commits HI/LO and raises the ID-stage stall for HI/LO-dependent instructions.
module md_ctrl
    import mips_md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic     clk,
    input  logic     reset,
    md_ctrl_if.slave bus
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 32'd1);

    md_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] core_res_s;
    logic        div_zero_s;

    md_core u_core (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .result   (core_res_s),
        .div_zero (div_zero_s)
    );

    // Next-state logic: issue in IDLE, count down and commit in RUN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.md_op)
                        MD_MULT, MD_MULTU: begin
                            op_d    = bus.md_op;
                            a_d     = bus.src_a;
                            b_d     = bus.src_b;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = ST_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            op_d    = bus.md_op;
                            a_d     = bus.src_a;
                            b_d     = bus.src_b;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = ST_RUN;
                        end
                        MD_MTHI: hi_d = bus.src_a;
                        MD_MTLO: lo_d = bus.src_a;
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    // A zero divisor burns the full latency but leaves HI/LO intact
                    if (!div_zero_s) begin
                        hi_d = core_res_s[63:32];
                        lo_d = core_res_s[31:0];
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, operand latches and architectural HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy     = (state_q == ST_RUN);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    // Unregistered so it lands in the same cycle as the hazard stall it is ORed into
    assign bus.stall_md = bus.md_useD & ((state_q == ST_RUN) | (bus.start & is_muldiv(bus.md_op)));

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed scenarios then random traffic,
// compared each cycle against an arithmetic reference model.
module tb_md_ctrl;
    import mips_md_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    // Reference model state
    logic [31:0] m_hi, m_lo, m_rh, m_rl;
    bit          m_valid;
    int          m_left;

    md_ctrl_if bus();

    md_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        logic [63:0] v;
        m_valid = 1'b1;
        v = 64'd0;
        case (op)
            3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); v = p; end
            3'd1: begin p = longint'(a) * longint'(b); v = p; end
            3'd2: begin
                if (b == 32'd0) m_valid = 1'b0;
                else begin
                    v[31:0]  = 32'(longint'($signed(a)) / longint'($signed(b)));
                    v[63:32] = 32'(longint'($signed(a)) % longint'($signed(b)));
                end
            end
            3'd3: begin
                if (b == 32'd0) m_valid = 1'b0;
                else begin
                    v[31:0]  = a / b;
                    v[63:32] = a % b;
                end
            end
            default: m_valid = 1'b0;
        endcase
        m_rh = v[63:32];
        m_rl = v[31:0];
    endtask

    task automatic cycle(input logic rst, input logic st, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic use_d);
        logic exp_stall;
        reset         = rst;
        bus.start     = st;
        bus.md_op     = op;
        bus.src_a     = a;
        bus.src_b     = b;
        bus.md_useD   = use_d;
        #2;
        exp_stall = use_d & ((m_left > 0) | (st & (op <= 3'd3)));
        chk("stall_md", {31'd0, bus.stall_md}, {31'd0, exp_stall});
        @(posedge clk);
        if (rst) begin
            m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_valid = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_valid) begin
                m_hi = m_rh;
                m_lo = m_rl;
            end
        end else if (st) begin
            case (op)
                3'd0, 3'd1: begin m_left = MULT_N; calc(op, a, b); end
                3'd2, 3'd3: begin m_left = DIV_N;  calc(op, a, b); end
                3'd4: m_hi = a;
                3'd5: m_lo = a;
                default: m_left = 0;
            endcase
        end
        #1;
        chk("busy", {31'd0, bus.busy}, {31'd0, (m_left > 0)});
        chk("hi", bus.hi, m_hi);
        chk("lo", bus.lo, m_lo);
    endtask

    task automatic idle(input int n, input logic use_d);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, use_d);
    endtask

    initial begin
        logic [31:0] rb;
        n_checks = 0; n_pass = 0;
        m_hi = 32'd0; m_lo = 32'd0; m_rh = 32'd0; m_rl = 32'd0; m_valid = 1'b0; m_left = 0;
        reset = 1'b1; bus.start = 1'b0; bus.md_op = 3'd0;
        bus.src_a = 32'd0; bus.src_b = 32'd0; bus.md_useD = 1'b0;

        cycle(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        cycle(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);

        // MULT / MULTU of -2 and 3
        cycle(1'b0, 1'b1, MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle(MULT_N, 1'b0);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFFA);
        cycle(1'b0, 1'b1, MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle(MULT_N, 1'b0);
        chk("multu_hi", bus.hi, 32'h0000_0002);
        chk("multu_lo", bus.lo, 32'hFFFF_FFFA);

        // Signed division including the overflow corner
        cycle(1'b0, 1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(DIV_N, 1'b0);
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);
        cycle(1'b0, 1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(DIV_N, 1'b0);
        chk("divovf_lo", bus.lo, 32'h8000_0000);
        chk("divovf_hi", bus.hi, 32'h0000_0000);

        // Divide by zero keeps preloaded HI/LO
        cycle(1'b0, 1'b1, MD_MTHI, 32'h11, 32'd0, 1'b0);
        cycle(1'b0, 1'b1, MD_MTLO, 32'h22, 32'd0, 1'b0);
        cycle(1'b0, 1'b1, MD_DIVU, 32'd1234, 32'd0, 1'b0);
        idle(DIV_N, 1'b0);
        chk("dz_hi", bus.hi, 32'h11);
        chk("dz_lo", bus.lo, 32'h22);

        // Stall window and ignored second start mid-RUN
        cycle(1'b0, 1'b1, MD_MULT, 32'd7, 32'd9, 1'b1);
        idle(2, 1'b1);
        cycle(1'b0, 1'b1, MD_DIVU, 32'd100, 32'd3, 1'b1);
        idle(MULT_N - 3, 1'b1);
        cycle(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        chk("ign_lo", bus.lo, 32'd63);
        chk("ign_hi", bus.hi, 32'd0);

        // Reset on cycle 3 of a DIV, with a coincident start
        cycle(1'b0, 1'b1, MD_DIV, 32'd1000, 32'd7, 1'b0);
        idle(2, 1'b0);
        cycle(1'b1, 1'b1, MD_MULT, 32'd5, 32'd5, 1'b0);
        idle(DIV_N + 2, 1'b0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);

        // MTLO then MULTU back to back, then a start as busy falls
        cycle(1'b0, 1'b1, MD_MTLO, 32'd5, 32'd0, 1'b0);
        cycle(1'b0, 1'b1, MD_MULTU, 32'd4, 32'd4, 1'b0);
        idle(MULT_N, 1'b0);
        chk("b2b_lo", bus.lo, 32'd16);
        chk("b2b_hi", bus.hi, 32'd0);
        cycle(1'b0, 1'b1, MD_DIVU, 32'd100, 32'd7, 1'b0);
        chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
        idle(DIV_N, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 9));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
                  3'($urandom_range(0, 5)), $urandom, rb, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
